// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings and default width.
package logic_unit_pipe_pkg;

    localparam int unsigned LU_DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        LU_OP_AND  = 3'd0,
        LU_OP_OR   = 3'd1,
        LU_OP_NAND = 3'd2,
        LU_OP_NOR  = 3'd3,
        LU_OP_XOR  = 3'd4,
        LU_OP_XNOR = 3'd5,
        LU_OP_NOT  = 3'd6,
        LU_OP_BUF  = 3'd7
    } lu_op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational op decode and bitwise compute for the logic unit, plus the result-is-zero flag.
module logic_op_comb
    import logic_unit_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = LU_DEFAULT_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o
);

    always_comb begin
        res_o = '0;
        case (lu_op_e'(op_i))
            LU_OP_AND:  res_o = a_i & b_i;
            LU_OP_OR:   res_o = a_i | b_i;
            LU_OP_NAND: res_o = ~(a_i & b_i);
            LU_OP_NOR:  res_o = ~(a_i | b_i);
            LU_OP_XOR:  res_o = a_i ^ b_i;
            LU_OP_XNOR: res_o = ~(a_i ^ b_i);
            LU_OP_NOT:  res_o = ~a_i;
            LU_OP_BUF:  res_o = a_i;
            default:    res_o = a_i;
        endcase
        zero_o = (res_o == '0);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit (operand stage S1, result stage S2).
// Optional completed-result counter on op_count when LOGIC_UNIT_PIPE_CNT_EN is defined.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = LU_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_in0_q, s1_in0_d;
    logic [WIDTH-1:0] s1_in1_q, s1_in1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;

    logic             s1_advance;
    logic             s1_load;
    logic [WIDTH-1:0] comb_res;
    logic             comb_zero;

    logic_op_comb #(
        .WIDTH(WIDTH)
    ) u_op (
        .op_i  (s1_op_q),
        .a_i   (s1_in0_q),
        .b_i   (s1_in1_q),
        .res_o (comb_res),
        .zero_o(comb_zero)
    );

    always_comb begin
        s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
        s1_load    = in_valid && (!s1_valid_q || s1_advance);
        // Ready reads as high during reset so the producer never sees a stale stall.
        in_ready   = rst || !s1_valid_q || s1_advance;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_in0_d   = s1_in0_q;
        s1_in1_d   = s1_in1_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_in0_d   = in0;
            s1_in1_d   = in1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        s2_res_d   = s2_res_q;
        s2_zero_d  = s2_zero_q;
        s2_valid_d = s1_advance || (s2_valid_q && !out_ready);
        if (s1_advance) begin
            s2_res_d  = comb_res;
            s2_zero_d = comb_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_in0_q   <= '0;
            s1_in1_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zero_q  <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_in0_q   <= s1_in0_d;
            s1_in1_q   <= s1_in1_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = s2_res_q;
    assign out_zero  = s2_zero_q;

`ifdef LOGIC_UNIT_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Free-running wrap on overflow; no saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule
